spi_command_sender: RTL

SPI_COMMAND_SENDER -- requirements
Module: spi_command_sender

---
 rtl/spi_command_sender_pkg.sv | 32 +++
 rtl/spi_byte_writer.sv | 51 +++++
 rtl/spi_command_sender.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_command_sender_pkg.sv
// Shared constants and types for the SPI command sender.
// Holds the command codes, sprite geometry, default SCK divider,
// shifter widths and the sender FSM state encoding.
package spi_command_sender_pkg;

   // Command byte codes understood by the display controller
   localparam logic [7:0] COMMAND_NOP         = 8'h00;
   localparam logic [7:0] COMMAND_SAVE_SPRITE = 8'h01;
   localparam logic [7:0] COMMAND_DRAW        = 8'h02;

   // Sprite memory geometry seen by the receiving side
   localparam int unsigned SPRITE_NUM       = 512;
   localparam int unsigned SPRITE_ADDR_SIZE = 9;

   // Default system clocks per SCK half-period
   localparam int unsigned SPI_CLK_DIV = 4;

   // Shifter geometry
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BIT_CNT_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_FETCH,
      ST_WAIT,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_e;

endpackage

// File: rtl/spi_byte_writer.sv
// MSB-first byte shifter with bit counter for the SPI command sender.
// Ports: clock/reset_n; load/load_data loads a new byte and clears the
// bit counter; shift advances one bit; clear empties the shifter so the
// line idles low; msb is the registered serial output; last_bit_c flags
// that the current bit is bit 0 of the byte.
module spi_byte_writer
   import spi_command_sender_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load,
   input  logic [BYTE_W-1:0] load_data,
   input  logic              shift,
   input  logic              clear,
   output logic              msb,
   output logic              last_bit_c
);

   logic [BYTE_W-1:0]    sr_q, sr_d;
   logic [BIT_CNT_W-1:0] bit_q, bit_d;

   // Shift register and bit counter update
   always_comb begin
      sr_d  = sr_q;
      bit_d = bit_q;
      if (clear) begin
         sr_d  = '0;
         bit_d = '0;
      end else if (load) begin
         sr_d  = load_data;
         bit_d = '0;
      end else if (shift) begin
         sr_d  = {sr_q[BYTE_W-2:0], 1'b0};
         bit_d = bit_q + BIT_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sr_q  <= '0;
         bit_q <= '0;
      end else begin
         sr_q  <= sr_d;
         bit_q <= bit_d;
      end
   end

   assign msb        = sr_q[BYTE_W-1];
   assign last_bit_c = (bit_q == BIT_CNT_W'(BYTE_W - 1));

endmodule

// File: rtl/spi_command_sender.sv
// SPI mode-0 master that sends a command byte followed by len payload
// bytes fetched one at a time from an external byte memory.
// Ports: clock/reset_n; start/cmd/len request a frame (sampled in IDLE);
// rd_req/rd_addr/rd_data fetch payload bytes (data one clock after req);
// busy covers the whole frame plus the inter-frame gap; done pulses when
// cs_n deasserts; cs_n/sck/mosi are the SPI master lines.
module spi_command_sender
   import spi_command_sender_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  cmd,
   input  logic [15:0] len,
   output logic        rd_req,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic        busy,
   output logic        done,
   output logic        cs_n,
   output logic        sck,
   output logic        mosi
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       idx_q, idx_d;
   logic [15:0]       rd_addr_q, rd_addr_d;
   logic              sck_q, sck_d;
   logic              cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_req_q, rd_req_d;

   logic              phase_end_c;
   logic              bw_load_c, bw_shift_c, bw_clear_c, bw_last_c;
   logic [7:0]        bw_data_c;
   logic              bw_msb;

   spi_byte_writer u_byte_writer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (bw_load_c),
      .load_data  (bw_data_c),
      .shift      (bw_shift_c),
      .clear      (bw_clear_c),
      .msb        (bw_msb),
      .last_bit_c (bw_last_c)
   );

   assign phase_end_c = (cnt_q == CNT_LAST);

   // Next-state, SCK phase timing and shifter control
   always_comb begin
      state_d    = state_q;
      cnt_d      = phase_end_c ? '0 : cnt_q + CNT_W'(1);
      len_d      = len_q;
      idx_d      = idx_q;
      rd_addr_d  = rd_addr_q;
      sck_d      = sck_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_req_d   = 1'b0;
      bw_load_c  = 1'b0;
      bw_data_c  = cmd;
      bw_shift_c = 1'b0;
      bw_clear_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d   = ST_SETUP;
               busy_d    = 1'b1;
               cs_n_d    = 1'b0;
               len_d     = len;
               idx_d     = '0;
               bw_load_c = 1'b1;
            end
         end
         // Low phase ahead of the first cmd bit
         ST_SETUP: begin
            if (phase_end_c) begin
               state_d = ST_SHIFT;
               sck_d   = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (phase_end_c) begin
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  if (!bw_last_c) begin
                     bw_shift_c = 1'b1;
                  end else if (idx_q != len_q) begin
                     state_d   = ST_FETCH;
                     rd_req_d  = 1'b1;
                     rd_addr_d = idx_q;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end
            end
         end
         ST_FETCH: begin
            cnt_d   = '0;
            idx_d   = idx_q + 16'd1;
            state_d = ST_WAIT;
         end
         // rd_data is valid here; next SHIFT starts with a low phase
         ST_WAIT: begin
            cnt_d     = '0;
            bw_load_c = 1'b1;
            bw_data_c = rd_data;
            state_d   = ST_SHIFT;
         end
         ST_HOLD: begin
            if (phase_end_c) begin
               state_d    = ST_GAP;
               cs_n_d     = 1'b1;
               done_d     = 1'b1;
               bw_clear_c = 1'b1;
            end
         end
         ST_GAP: begin
            if (phase_end_c) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         rd_addr_q <= '0;
         sck_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_req_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         rd_addr_q <= rd_addr_d;
         sck_q     <= sck_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_req_q  <= rd_req_d;
      end
   end

   assign rd_req  = rd_req_q;
   assign rd_addr = rd_addr_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign cs_n    = cs_n_q;
   assign sck     = sck_q;
   assign mosi    = bw_msb;

endmodule
